multi_timer: RTL

MULTI_TIMER -- requirements
Module: multi_timer

---
 rtl/timer_pkg.sv | 51 +++++
 rtl/timer_channel.sv | 84 ++++++++
 rtl/multi_timer.sv | 95 +++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared register map and field layout for multi_timer.
//   Per-channel word offsets (CTRL, CMP, CNT, STATUS), CTRL/STATUS bit
//   positions, prescaler width, CSR bit positions for MIE/MTIE, and
//   helpers that convert between the CTRL bus word and its fields.
package timer_pkg;

   localparam int         REG_OFF_W  = 2;
   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_CMP    = 2'd1;
   localparam logic [1:0] OFF_CNT    = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_ONESHOT_BIT = 1;
   localparam int CTRL_IE_BIT      = 2;
   localparam int CTRL_PRESC_LSB   = 8;
   localparam int PRESC_W          = 8;

   localparam int STATUS_PEND_BIT = 0;

   localparam int MSTATUS_MIE_BIT = 3;
   localparam int MIE_MTIE_BIT    = 7;

   typedef struct packed {
      logic               en;
      logic               oneshot;
      logic               ie;
      logic [PRESC_W-1:0] presc;
   } ctrl_t;

   // CTRL as seen on the bus; unassigned bits read 0.
   function automatic logic [31:0] pack_ctrl(ctrl_t c);
      logic [31:0] w;
      w = '0;
      w[CTRL_EN_BIT]                     = c.en;
      w[CTRL_ONESHOT_BIT]                = c.oneshot;
      w[CTRL_IE_BIT]                     = c.ie;
      w[CTRL_PRESC_LSB +: PRESC_W]       = c.presc;
      return w;
   endfunction

   function automatic ctrl_t unpack_ctrl(logic [31:0] w);
      ctrl_t c;
      c.en      = w[CTRL_EN_BIT];
      c.oneshot = w[CTRL_ONESHOT_BIT];
      c.ie      = w[CTRL_IE_BIT];
      c.presc   = w[CTRL_PRESC_LSB +: PRESC_W];
      return c;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer channel (CTRL, prescaler, counter, compare, PEND).
//   clk, reset        : clock, synchronous active-high reset
//   ctrl_we/cmp_we    : load CTRL / CMP from wdata at this edge
//   cnt_we            : clear CNT and prescaler (data ignored)
//   status_we         : write-1-to-clear PEND using wdata bit 0
//   wdata             : bus write data
//   ctrl_word         : CTRL register in bus layout
//   ie                : interrupt enable field of CTRL
//   cmp, cnt, pend    : compare value, current count, pending flag
module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ctrl_we,
   input  logic             cmp_we,
   input  logic             cnt_we,
   input  logic             status_we,
   input  logic [31:0]      wdata,
   output logic [31:0]      ctrl_word,
   output logic             ie,
   output logic [CNT_W-1:0] cmp,
   output logic [CNT_W-1:0] cnt,
   output logic             pend
);

   ctrl_t              ctrl_q;
   logic [PRESC_W-1:0] pre_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cmp_q;
   logic               pend_q;
   logic               tick;
   logic               match;
   logic               unused_wdata;

   // Tick closes each PRESC+1 cycle window; match uses the pre-edge CMP.
   assign tick  = ctrl_q.en && (pre_q == ctrl_q.presc);
   assign match = tick && (cnt_q == cmp_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q <= '0;
         cmp_q  <= '0;
         cnt_q  <= '0;
         pre_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         // A software CTRL write overrides the one-shot self-disable.
         if (ctrl_we)
            ctrl_q <= unpack_ctrl(wdata);
         else if (match && ctrl_q.oneshot)
            ctrl_q.en <= 1'b0;

         if (cmp_we)
            cmp_q <= wdata[CNT_W-1:0];

         if (cnt_we || !ctrl_q.en) begin
            cnt_q <= '0;
            pre_q <= '0;
         end else if (tick) begin
            pre_q <= '0;
            cnt_q <= match ? '0 : cnt_q + 1'b1;
         end else begin
            pre_q <= pre_q + 1'b1;
         end

         // A new match beats a coincident clear.
         if (match)
            pend_q <= 1'b1;
         else if (status_we && wdata[STATUS_PEND_BIT])
            pend_q <= 1'b0;
      end
   end

   assign ctrl_word    = pack_ctrl(ctrl_q);
   assign ie           = ctrl_q.ie;
   assign cmp          = cmp_q;
   assign cnt          = cnt_q;
   assign pend         = pend_q;
   assign unused_wdata = ^wdata;

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH memory-mapped timer channels with one interrupt line.
//   clk, reset             : clock, synchronous active-high reset
//   timer_read_address_in  : read word address
//   timer_read_data_out    : read data, combinational from the read address
//   timer_write_address_in : write word address
//   timer_write_data_in    : write data
//   timer_write_enable_in  : one write per asserted cycle
//   mstatus_data           : bit 3 = MIE
//   mie_data               : bit 7 = MTIE
//   timer_int_req          : registered level interrupt request
// Channel i occupies words BASE_ADDR+4*i .. BASE_ADDR+4*i+3.
module multi_timer
   import timer_pkg::*;
#(
   parameter int          NUM_CH    = 4,
   parameter int          CNT_W     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h9000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] timer_read_address_in,
   output logic [31:0] timer_read_data_out,
   input  logic [31:0] timer_write_address_in,
   input  logic [31:0] timer_write_data_in,
   input  logic        timer_write_enable_in,
   input  logic [31:0] mstatus_data,
   input  logic [31:0] mie_data,
   output logic        timer_int_req
);

   localparam int CH_IDX_W = 32 - REG_OFF_W;

   logic [31:0]       rd_off;
   logic [31:0]       wr_off;
   logic [31:0]       ctrl_v [NUM_CH];
   logic [CNT_W-1:0]  cmp_v  [NUM_CH];
   logic [CNT_W-1:0]  cnt_v  [NUM_CH];
   logic [NUM_CH-1:0] pend_v;
   logic [NUM_CH-1:0] ie_v;
   logic              irq_any;
   logic              unused_csr;

   // Offsets relative to the block; anything outside 0..4*NUM_CH-1 (including
   // addresses below BASE_ADDR, which wrap high) matches no channel index.
   assign rd_off = timer_read_address_in  - BASE_ADDR;
   assign wr_off = timer_write_address_in - BASE_ADDR;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = timer_write_enable_in &&
                   (wr_off[31:REG_OFF_W] == CH_IDX_W'(i));

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk       (clk),
         .reset     (reset),
         .ctrl_we   (sel && (wr_off[REG_OFF_W-1:0] == OFF_CTRL)),
         .cmp_we    (sel && (wr_off[REG_OFF_W-1:0] == OFF_CMP)),
         .cnt_we    (sel && (wr_off[REG_OFF_W-1:0] == OFF_CNT)),
         .status_we (sel && (wr_off[REG_OFF_W-1:0] == OFF_STATUS)),
         .wdata     (timer_write_data_in),
         .ctrl_word (ctrl_v[i]),
         .ie        (ie_v[i]),
         .cmp       (cmp_v[i]),
         .cnt       (cnt_v[i]),
         .pend      (pend_v[i])
      );
   end

   always_comb begin
      timer_read_data_out = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_off[31:REG_OFF_W] == CH_IDX_W'(i)) begin
            case (rd_off[REG_OFF_W-1:0])
               OFF_CTRL: timer_read_data_out = ctrl_v[i];
               OFF_CMP:  timer_read_data_out = 32'(cmp_v[i]);
               OFF_CNT:  timer_read_data_out = 32'(cnt_v[i]);
               default:  timer_read_data_out = 32'(pend_v[i]);
            endcase
         end
      end
   end

   assign irq_any = |(pend_v & ie_v);

   always_ff @(posedge clk) begin
      if (reset)
         timer_int_req <= 1'b0;
      else
         timer_int_req <= irq_any && mstatus_data[MSTATUS_MIE_BIT] &&
                          mie_data[MIE_MTIE_BIT];
   end

   assign unused_csr = ^{mstatus_data, mie_data};

endmodule
